// File: rtl/batcharger_adcseq.sv
// batcharger_adcseq: round-robin sequencer sharing one 8-bit SAR ADC across the V/I/T monitors.
// Optional macro ADCSEQ_AVG_EN: two back-to-back conversions per visit, rounded mean captured.
module batcharger_adcseq #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       en,
    input  logic       vmonen,
    input  logic       imonen,
    input  logic       tmonen,
    input  logic       adc_eoc,
    input  logic [7:0] adc_data,
    output logic [1:0] adc_sel,
    output logic       adc_soc,
    output logic [7:0] vbat,
    output logic [7:0] ibat,
    output logic [7:0] tbat,
    output logic       vtok,
    output logic       adc_err
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_L = 8'(SETTLE);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    function automatic logic [1:0] inc3(input logic [1:0] c);
        return (c >= 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // Returns {found, channel}; incl tries the current channel first, otherwise last.
    function automatic logic [2:0] pick_next(input logic [1:0] cur, input logic [2:0] req,
                                             input logic incl);
        logic [1:0] c;
        logic [2:0] res;
        res = 3'b000;
        c   = incl ? cur : inc3(cur);
        for (int k = 0; k < 3; k++) begin
            res = (!res[2] && req[c]) ? {1'b1, c} : res;
            c   = inc3(c);
        end
        return res;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       soc_q, soc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] vbat_q, vbat_d;
    logic [7:0] ibat_q, ibat_d;
    logic [7:0] tbat_q, tbat_d;
    logic [2:0] vld_q, vld_d;
    logic       err_q, err_d;
    logic       drop_q, drop_d;
    logic [2:0] req_s;
    logic [2:0] nxt_s;
    logic       cap_ok_s;
    logic [7:0] cap_val_s;

    assign req_s    = {tmonen, imonen, vmonen};
    assign nxt_s    = pick_next(sel_q, req_s, state_q == ST_IDLE);
    assign cap_ok_s = req_s[sel_q] & ~drop_q;

`ifdef ADCSEQ_AVG_EN
    logic       phase_q, phase_d;
    logic [7:0] s1_q, s1_d;
    logic [8:0] avg_sum_s;
    assign avg_sum_s = {1'b0, s1_q} + {1'b0, adc_data} + 9'd1;
    assign cap_val_s = avg_sum_s[8:1];
`else
    assign cap_val_s = adc_data;
`endif

    // Next-state, channel choice, capture and valid/error bookkeeping.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        vbat_d  = vbat_q;
        ibat_d  = ibat_q;
        tbat_d  = tbat_q;
        vld_d   = vld_q & req_s;
        err_d   = err_q;
        drop_d  = drop_q | ~req_s[sel_q];
`ifdef ADCSEQ_AVG_EN
        phase_d = phase_q;
        s1_d    = s1_q;
`endif
        if (!en) begin
            state_d = ST_IDLE;
            vld_d   = 3'b000;
            err_d   = 1'b0;
            drop_d  = 1'b0;
`ifdef ADCSEQ_AVG_EN
            phase_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    drop_d = 1'b0;
                    if (nxt_s[2]) begin
                        state_d = ST_SELECT;
                        sel_d   = nxt_s[1:0];
                        cnt_d   = SETTLE_L;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end
                ST_START: begin
                    state_d = ST_WAIT;
                    tmo_d   = 8'd0;
                end
                ST_WAIT: begin
                    if (adc_eoc) begin
`ifdef ADCSEQ_AVG_EN
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            s1_d    = adc_data;
                            state_d = ST_START;
                        end else begin
                            phase_d = 1'b0;
                            state_d = ST_CAPTURE;
                        end
                        if (phase_q && cap_ok_s) begin
`else
                        state_d = ST_CAPTURE;
                        if (cap_ok_s) begin
`endif
                            vld_d[sel_q] = 1'b1;
                            case (sel_q)
                                2'd0:    vbat_d = cap_val_s;
                                2'd1:    ibat_d = cap_val_s;
                                2'd2:    tbat_d = cap_val_s;
                                default: vbat_d = vbat_q;
                            endcase
                        end else begin
                            vld_d[sel_q] = vld_d[sel_q] & ~drop_d;
                        end
                    end else if (tmo_q >= TMO_LAST) begin
                        // Timed out: drop this channel's result and move on through a fresh settle.
                        vld_d[sel_q] = 1'b0;
                        err_d        = 1'b1;
                        drop_d       = 1'b0;
`ifdef ADCSEQ_AVG_EN
                        phase_d      = 1'b0;
`endif
                        if (nxt_s[2]) begin
                            state_d = ST_SELECT;
                            sel_d   = nxt_s[1:0];
                            cnt_d   = SETTLE_L;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    drop_d = 1'b0;
                    if (!nxt_s[2]) begin
                        state_d = ST_IDLE;
                    end else if (nxt_s[1:0] == sel_q) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_SELECT;
                        sel_d   = nxt_s[1:0];
                        cnt_d   = SETTLE_L;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        soc_d = (state_d == ST_START);
    end

    // State, control and result registers.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            soc_q   <= 1'b0;
            cnt_q   <= 8'd0;
            tmo_q   <= 8'd0;
            vbat_q  <= 8'd0;
            ibat_q  <= 8'd0;
            tbat_q  <= 8'd0;
            vld_q   <= 3'b000;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
`ifdef ADCSEQ_AVG_EN
            phase_q <= 1'b0;
            s1_q    <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            soc_q   <= soc_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            vbat_q  <= vbat_d;
            ibat_q  <= ibat_d;
            tbat_q  <= tbat_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
`ifdef ADCSEQ_AVG_EN
            phase_q <= phase_d;
            s1_q    <= s1_d;
`endif
        end
    end

    assign adc_sel = sel_q;
    assign adc_soc = soc_q;
    assign vbat    = vbat_q;
    assign ibat    = ibat_q;
    assign tbat    = tbat_q;
    assign adc_err = err_q;
    assign vtok    = (vmonen | tmonen) & (~vmonen | vld_q[0]) & (~tmonen | vld_q[2]);

endmodule
